// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the fetch-stage pipeline controller.
package pipeline_ctrl_pkg;

   // BOOT holds the PC for one cycle, RUN is normal flow, FLUSH squashes
   // the extra front-end slots left behind by a taken branch.
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   // addi x0, x0, 0 -- the encoding IF/ID and ID/EX load when cleared.
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   localparam int REG_W_DEFAULT = 5;

endpackage

// File: rtl/fetch_hazard_control_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int COUNT_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               clear_i,
   output logic [COUNT_W-1:0] count_o
);

   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;

   // Next count: clear wins, otherwise increment unless already saturated.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + COUNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_hazard_control.sv
// Fetch-stage stall/flush sequencer with load-use detection and
// saturating stall/flush performance counters.
//
// state | meaning
// BOOT  | one cycle after reset: PC held so instruction memory settles
// RUN   | normal fetch; handles freeze, redirect, load-use stall
// FLUSH | extra squash cycles after a taken branch (FLUSH_CYCLES > 1)
module fetch_hazard_control
   import pipeline_ctrl_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int REG_W        = REG_W_DEFAULT,
   parameter int FLUSH_CYCLES = 1,
   parameter int COUNT_W      = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ext_stall,
   input  logic [REG_W-1:0]   id_rs1,
   input  logic [REG_W-1:0]   id_rs2,
   input  logic               id_uses_rs1,
   input  logic               id_uses_rs2,
   input  logic               ex_mem_read,
   input  logic [REG_W-1:0]   ex_rd,
   input  logic               branch_taken,
   input  logic [XLEN-1:0]    branch_target,
   output logic               load_pc,
   output logic               load_if_id_register,
   output logic               mux_sel,
   output logic [XLEN-1:0]    pc_branch_value,
   output logic               if_id_flush,
   output logic               id_ex_bubble,
   output logic [COUNT_W-1:0] stall_count,
   output logic [COUNT_W-1:0] flush_count
);

   // The branch cycle itself is the first squash slot, so FLUSH covers the rest.
   localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

   fetch_state_e state_q, state_d;
   logic [1:0]   flush_left_q, flush_left_d;
   logic         load_use;
   logic         stall_inc;
   logic         flush_inc;
   logic         cnt_clear;

   // A register index of zero is hardwired, so a load to x0 never hazards.
   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   assign cnt_clear = (state_q == BOOT);

   // Next state and Mealy control outputs; everything forced low during reset.
   always_comb begin
      state_d             = state_q;
      flush_left_d        = flush_left_q;
      load_pc             = 1'b0;
      load_if_id_register = 1'b0;
      mux_sel             = 1'b0;
      pc_branch_value     = '0;
      if_id_flush         = 1'b0;
      id_ex_bubble        = 1'b0;
      stall_inc           = 1'b0;
      flush_inc           = 1'b0;

      case (state_q)
         BOOT: begin
            id_ex_bubble = 1'b1;
            state_d      = RUN;
         end
         RUN: begin
            if (ext_stall) begin
               // EX is frozen too, so a pending branch will be re-presented.
               stall_inc = 1'b1;
            end else if (branch_taken) begin
               load_pc             = 1'b1;
               load_if_id_register = 1'b1;
               mux_sel             = 1'b1;
               pc_branch_value     = branch_target;
               if_id_flush         = 1'b1;
               id_ex_bubble        = 1'b1;
               flush_inc           = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  flush_left_d = FLUSH_INIT;
                  state_d      = FLUSH;
               end
            end else if (load_use) begin
               id_ex_bubble = 1'b1;
               stall_inc    = 1'b1;
            end else begin
               load_pc             = 1'b1;
               load_if_id_register = 1'b1;
            end
         end
         FLUSH: begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (ext_stall) begin
               stall_inc = 1'b1;
            end else begin
               load_pc             = 1'b1;
               load_if_id_register = 1'b1;
               if (flush_left_q <= 2'd1) begin
                  state_d = RUN;
               end else begin
                  flush_left_d = flush_left_q - 2'd1;
               end
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      if (!reset) begin
         load_pc             = 1'b0;
         load_if_id_register = 1'b0;
         mux_sel             = 1'b0;
         pc_branch_value     = '0;
         if_id_flush         = 1'b0;
         id_ex_bubble        = 1'b0;
         stall_inc           = 1'b0;
         flush_inc           = 1'b0;
      end
   end

   // State and flush down-counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= BOOT;
         flush_left_q <= 2'd0;
      end else begin
         state_q      <= state_d;
         flush_left_q <= flush_left_d;
      end
   end

   sat_counter #(.COUNT_W(COUNT_W)) u_stall_cnt (
      .clk_i   (clock),
      .rst_ni  (reset),
      .en_i    (stall_inc),
      .clear_i (cnt_clear),
      .count_o (stall_count)
   );

   sat_counter #(.COUNT_W(COUNT_W)) u_flush_cnt (
      .clk_i   (clock),
      .rst_ni  (reset),
      .en_i    (flush_inc),
      .clear_i (cnt_clear),
      .count_o (flush_count)
   );

endmodule

// File: tb/tb_fetch_hazard_control.sv
// Directed bench: default-parameter instance for the vector table, a
// FLUSH_CYCLES=3 / COUNT_W=4 instance for the multi-cycle sequences.
module tb_fetch_hazard_control;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ext_stall, id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic [31:0] branch_target;

   logic        a_lp, a_li, a_mux, a_fl, a_bb;
   logic [31:0] a_pcv;
   logic [15:0] a_sc, a_fc;
   logic        b_lp, b_li, b_mux, b_fl, b_bb;
   logic [31:0] b_pcv;
   logic [3:0]  b_sc, b_fc;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   fetch_hazard_control dut_a (
      .clock(clock), .reset(reset), .ext_stall(ext_stall),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .branch_target(branch_target), .load_pc(a_lp), .load_if_id_register(a_li),
      .mux_sel(a_mux), .pc_branch_value(a_pcv), .if_id_flush(a_fl), .id_ex_bubble(a_bb),
      .stall_count(a_sc), .flush_count(a_fc)
   );

   fetch_hazard_control #(.FLUSH_CYCLES(3), .COUNT_W(4)) dut_b (
      .clock(clock), .reset(reset), .ext_stall(ext_stall),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .branch_target(branch_target), .load_pc(b_lp), .load_if_id_register(b_li),
      .mux_sel(b_mux), .pc_branch_value(b_pcv), .if_id_flush(b_fl), .id_ex_bubble(b_bb),
      .stall_count(b_sc), .flush_count(b_fc)
   );

   typedef struct {
      logic        stall;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        u1;
      logic        u2;
      logic        mr;
      logic [4:0]  rd;
      logic        br;
      logic [31:0] tgt;
      logic        lp;
      logic        li;
      logic        mux;
      logic [31:0] pcv;
      logic        fl;
      logic        bb;
      int          sc;
      int          fc;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      ext_stall = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
      branch_taken = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; branch_target = 0;
   endtask

   // Enter reset mid-cycle, release just after an edge: caller is then in BOOT.
   task automatic do_reset();
      clear_inputs();
      reset = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      vecs[0]  = '{0,0,0,0,0,0,0,0,32'h0,  1,1,0,32'h0, 0,0, 0,0};
      vecs[1]  = '{0,0,5,0,1,1,5,0,32'h0,  0,0,0,32'h0, 0,1, 0,0};
      vecs[2]  = '{0,0,0,0,0,0,0,0,32'h0,  1,1,0,32'h0, 0,0, 1,0};
      vecs[3]  = '{0,0,0,0,1,1,0,0,32'h0,  1,1,0,32'h0, 0,0, 1,0};
      vecs[4]  = '{0,7,0,1,0,1,7,0,32'h0,  0,0,0,32'h0, 0,1, 1,0};
      vecs[5]  = '{0,7,0,0,0,1,7,0,32'h0,  1,1,0,32'h0, 0,0, 2,0};
      vecs[6]  = '{0,7,0,1,0,0,7,0,32'h0,  1,1,0,32'h0, 0,0, 2,0};
      vecs[7]  = '{0,0,5,0,1,1,5,1,32'h40, 1,1,1,32'h40,1,1, 2,0};
      vecs[8]  = '{1,0,0,0,0,0,0,1,32'h80, 0,0,0,32'h0, 0,0, 2,1};
      vecs[9]  = '{0,0,0,0,0,0,0,1,32'h80, 1,1,1,32'h80,1,1, 3,1};
      vecs[10] = '{1,0,5,0,1,1,5,0,32'h0,  0,0,0,32'h0, 0,0, 3,2};
      vecs[11] = '{0,0,0,0,0,0,0,0,32'h0,  1,1,0,32'h0, 0,0, 4,2};

      // Reset with hostile inputs: every output must be forced low.
      clear_inputs();
      #2 reset = 0;
      branch_taken = 1; branch_target = 32'h40; ex_mem_read = 1; ex_rd = 5;
      id_rs2 = 5; id_uses_rs2 = 1;
      repeat (3) begin
         @(negedge clock);
         chk("rst_lp", a_lp, 0);   chk("rst_li", a_li, 0);  chk("rst_mux", a_mux, 0);
         chk("rst_pcv", a_pcv, 0); chk("rst_fl", a_fl, 0);  chk("rst_bb", a_bb, 0);
         chk("rst_sc", a_sc, 0);   chk("rst_fc", a_fc, 0);
      end
      @(posedge clock);
      #1 reset = 1;
      clear_inputs();
      #3;
      chk("boot_lp", a_lp, 0); chk("boot_li", a_li, 0); chk("boot_bb", a_bb, 1);
      chk("boot_mux", a_mux, 0); chk("boot_fl", a_fl, 0);
      next_cycle(); #3;
      chk("run_lp", a_lp, 1); chk("run_li", a_li, 1); chk("run_mux", a_mux, 0);
      chk("run_bb", a_bb, 0);

      // Vector table on the single-flush-cycle instance.
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         ext_stall = vecs[i].stall; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
         id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2; ex_mem_read = vecs[i].mr;
         ex_rd = vecs[i].rd; branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
         #3;
         chk($sformatf("v%0d_lp", i), a_lp, vecs[i].lp);
         chk($sformatf("v%0d_li", i), a_li, vecs[i].li);
         chk($sformatf("v%0d_mux", i), a_mux, vecs[i].mux);
         chk($sformatf("v%0d_pcv", i), a_pcv, vecs[i].pcv);
         chk($sformatf("v%0d_fl", i), a_fl, vecs[i].fl);
         chk($sformatf("v%0d_bb", i), a_bb, vecs[i].bb);
         chk($sformatf("v%0d_sc", i), a_sc, 32'(vecs[i].sc));
         chk($sformatf("v%0d_fc", i), a_fc, 32'(vecs[i].fc));
      end

      // Three-cycle flush; a branch pulse inside FLUSH is ignored.
      do_reset();
      next_cycle();
      next_cycle(); branch_taken = 1; branch_target = 32'h40; #3;
      chk("f3_t_fl", b_fl, 1); chk("f3_t_mux", b_mux, 1); chk("f3_t_pcv", b_pcv, 32'h40);
      next_cycle(); branch_target = 32'h100; #3;
      chk("f3_t1_fl", b_fl, 1); chk("f3_t1_mux", b_mux, 0); chk("f3_t1_pcv", b_pcv, 0);
      chk("f3_t1_lp", b_lp, 1); chk("f3_t1_bb", b_bb, 1);
      chk("f1_t1_pcv", a_pcv, 32'h100);
      next_cycle(); branch_taken = 0; #3;
      chk("f3_t2_fl", b_fl, 1); chk("f1_t2_fl", a_fl, 0);
      next_cycle(); #3;
      chk("f3_t3_fl", b_fl, 0); chk("f3_t3_lp", b_lp, 1); chk("f3_t3_fc", b_fc, 1);
      chk("f1_t3_fc", a_fc, 2);

      // Freeze inside FLUSH stretches it by one cycle.
      do_reset();
      next_cycle();
      next_cycle(); branch_taken = 1; branch_target = 32'h40; #3;
      chk("fx_t_fl", b_fl, 1);
      next_cycle(); branch_taken = 0; ext_stall = 1; #3;
      chk("fx_t1_fl", b_fl, 1); chk("fx_t1_bb", b_bb, 1); chk("fx_t1_lp", b_lp, 0);
      chk("fx_t1_li", b_li, 0);
      next_cycle(); ext_stall = 0; #3;
      chk("fx_t2_fl", b_fl, 1); chk("fx_t2_lp", b_lp, 1);
      next_cycle(); #3;
      chk("fx_t3_fl", b_fl, 1);
      next_cycle(); #3;
      chk("fx_t4_fl", b_fl, 0); chk("fx_t4_sc", b_sc, 1);

      // Saturation: 20 frozen cycles.
      do_reset();
      next_cycle();
      ext_stall = 1;
      repeat (20) @(posedge clock);
      #1 ext_stall = 0;
      #3;
      chk("sat_b_sc", b_sc, 15); chk("sat_a_sc", a_sc, 20);

      // Reset in the middle of FLUSH clears everything at once.
      next_cycle(); branch_taken = 1; branch_target = 32'h40;
      next_cycle(); branch_taken = 0; #2;
      chk("mid_fl", b_fl, 1); chk("mid_fc", b_fc, 1);
      #1 reset = 0;
      #1;
      chk("arst_sc", b_sc, 0); chk("arst_fc", b_fc, 0); chk("arst_fl", b_fl, 0);
      chk("arst_lp", b_lp, 0); chk("arst_bb", b_bb, 0);
      @(posedge clock);
      #1 reset = 1;
      #3;
      chk("reboot_lp", b_lp, 0); chk("reboot_bb", b_bb, 1); chk("reboot_fl", b_fl, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
